// File: rtl/axi_arb_pkg.sv
// Shared types for the 2x1 AXI master arbiter: FSM state enums, owner index
// and AXI response encodings.
package axi_arb_pkg;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    WR_IDLE = 2'd0,
    WR_REQ  = 2'd1,
    WR_RESP = 2'd2
  } wr_state_t;

  typedef logic owner_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi_master_arbiter_2x1_if.sv
// AXI4 subset (AR/R/AW/W/B, no IDs) used for both requester ports and the
// shared master port.
interface axi_master_arbiter_2x1_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 8
);
  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [LEN_W-1:0]  arlen;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [LEN_W-1:0]  awlen;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic       bvalid;
  logic       bready;
  logic [1:0] bresp;

  // Issuer of transactions.
  modport master (
    output arvalid, araddr, arlen, rready,
    output awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
    input  arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );

  // Responder to transactions.
  modport slave (
    input  arvalid, araddr, arlen, rready,
    input  awvalid, awaddr, awlen, wvalid, wdata, wstrb, wlast, bready,
    output arready, rvalid, rdata, rresp, rlast, awready, wready, bvalid, bresp
  );
endinterface

// File: rtl/rr_arbiter_2.sv
// Two-way priority picker. With AXI_ARB_FIXED_PRIO_EN defined port 0 always
// wins and no pointer exists; otherwise round-robin with a pointer register.
module rr_arbiter_2
  import axi_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       done,
  input  owner_t     done_owner,
  output owner_t     grant
);

`ifdef AXI_ARB_FIXED_PRIO_EN
  logic unused_fixed;
  assign unused_fixed = ^{clk, rst, done, done_owner};
  assign grant = req[0] ? 1'b0 : 1'b1;
`else
  owner_t ptr;  // port currently favoured

  always_ff @(posedge clk) begin
    if (rst)       ptr <= 1'b0;
    else if (done) ptr <= ~done_owner;
  end

  assign grant = req[ptr] ? ptr : ~ptr;
`endif

endmodule

// File: rtl/axi_master_arbiter_2x1.sv
// Shares one AXI4 master port between two requesters; independent read and
// write FSMs, one outstanding transaction each. See rr_arbiter_2 for AXI_ARB_FIXED_PRIO_EN.
module axi_master_arbiter_2x1
  import axi_arb_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst,
  axi_master_arbiter_2x1_if.slave   s0,
  axi_master_arbiter_2x1_if.slave   s1,
  axi_master_arbiter_2x1_if.master  m
);

  rd_state_t rd_state;
  wr_state_t wr_state;
  owner_t    rd_owner, wr_owner, rd_grant, wr_grant;
  logic      aw_done, w_done;

  logic ar_sel_valid, r_sel_ready, aw_sel_valid, w_sel_valid, w_sel_last, b_sel_ready;
  logic rd_ar_hs, rd_last_hs, wr_aw_hs, wr_w_last_hs, wr_b_hs;

  assign ar_sel_valid = rd_owner ? s1.arvalid : s0.arvalid;
  assign r_sel_ready  = rd_owner ? s1.rready  : s0.rready;
  assign aw_sel_valid = wr_owner ? s1.awvalid : s0.awvalid;
  assign w_sel_valid  = wr_owner ? s1.wvalid  : s0.wvalid;
  assign w_sel_last   = wr_owner ? s1.wlast   : s0.wlast;
  assign b_sel_ready  = wr_owner ? s1.bready  : s0.bready;

  assign rd_ar_hs     = (rd_state == RD_ADDR) && ar_sel_valid && m.arready;
  assign rd_last_hs   = (rd_state == RD_DATA) && m.rvalid && r_sel_ready && m.rlast;
  assign wr_aw_hs     = (wr_state == WR_REQ) && !aw_done && aw_sel_valid && m.awready;
  assign wr_w_last_hs = (wr_state == WR_REQ) && !w_done && w_sel_valid && w_sel_last && m.wready;
  assign wr_b_hs      = (wr_state == WR_RESP) && m.bvalid && b_sel_ready;

  rr_arbiter_2 u_rd_arb (
    .clk(clk), .rst(rst), .req({s1.arvalid, s0.arvalid}),
    .done(rd_last_hs), .done_owner(rd_owner), .grant(rd_grant)
  );

  rr_arbiter_2 u_wr_arb (
    .clk(clk), .rst(rst), .req({s1.awvalid, s0.awvalid}),
    .done(wr_b_hs), .done_owner(wr_owner), .grant(wr_grant)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_state <= RD_IDLE;
      rd_owner <= 1'b0;
    end else begin
      case (rd_state)
        RD_IDLE: if (s0.arvalid || s1.arvalid) begin
          rd_owner <= rd_grant;
          rd_state <= RD_ADDR;
        end
        RD_ADDR: if (rd_ar_hs)   rd_state <= RD_DATA;
        RD_DATA: if (rd_last_hs) rd_state <= RD_IDLE;
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

  // AW and W complete independently in either order; dones clear on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state <= WR_IDLE;
      wr_owner <= 1'b0;
      aw_done  <= 1'b0;
      w_done   <= 1'b0;
    end else begin
      case (wr_state)
        WR_IDLE: if (s0.awvalid || s1.awvalid) begin
          wr_owner <= wr_grant;
          wr_state <= WR_REQ;
        end
        WR_REQ: begin
          if (wr_aw_hs)     aw_done <= 1'b1;
          if (wr_w_last_hs) w_done  <= 1'b1;
          if ((aw_done || wr_aw_hs) && (w_done || wr_w_last_hs)) begin
            wr_state <= WR_RESP;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
          end
        end
        WR_RESP: if (wr_b_hs) wr_state <= WR_IDLE;
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  always_comb begin
    m.arvalid  = 1'b0;
    m.araddr   = '0;
    m.arlen    = '0;
    m.rready   = 1'b0;
    m.awvalid  = 1'b0;
    m.awaddr   = '0;
    m.awlen    = '0;
    m.wvalid   = 1'b0;
    m.wdata    = '0;
    m.wstrb    = '0;
    m.wlast    = 1'b0;
    m.bready   = 1'b0;
    s0.arready = 1'b0;
    s0.rvalid  = 1'b0;
    s0.rdata   = '0;
    s0.rresp   = '0;
    s0.rlast   = 1'b0;
    s0.awready = 1'b0;
    s0.wready  = 1'b0;
    s0.bvalid  = 1'b0;
    s0.bresp   = '0;
    s1.arready = 1'b0;
    s1.rvalid  = 1'b0;
    s1.rdata   = '0;
    s1.rresp   = '0;
    s1.rlast   = 1'b0;
    s1.awready = 1'b0;
    s1.wready  = 1'b0;
    s1.bvalid  = 1'b0;
    s1.bresp   = '0;

    case (rd_state)
      RD_ADDR: begin
        m.arvalid = ar_sel_valid;
        m.araddr  = rd_owner ? s1.araddr : s0.araddr;
        m.arlen   = rd_owner ? s1.arlen  : s0.arlen;
        if (rd_owner) s1.arready = m.arready;
        else          s0.arready = m.arready;
      end
      RD_DATA: begin
        m.rready = r_sel_ready;
        if (rd_owner) begin
          s1.rvalid = m.rvalid; s1.rdata = m.rdata; s1.rresp = m.rresp; s1.rlast = m.rlast;
        end else begin
          s0.rvalid = m.rvalid; s0.rdata = m.rdata; s0.rresp = m.rresp; s0.rlast = m.rlast;
        end
      end
      default: ;
    endcase

    case (wr_state)
      WR_REQ: begin
        m.awvalid = aw_sel_valid && !aw_done;
        m.awaddr  = wr_owner ? s1.awaddr : s0.awaddr;
        m.awlen   = wr_owner ? s1.awlen  : s0.awlen;
        m.wvalid  = w_sel_valid && !w_done;
        m.wdata   = wr_owner ? s1.wdata : s0.wdata;
        m.wstrb   = wr_owner ? s1.wstrb : s0.wstrb;
        m.wlast   = w_sel_last;
        if (wr_owner) begin
          s1.awready = m.awready && !aw_done;
          s1.wready  = m.wready && !w_done;
        end else begin
          s0.awready = m.awready && !aw_done;
          s0.wready  = m.wready && !w_done;
        end
      end
      WR_RESP: begin
        m.bready = b_sel_ready;
        if (wr_owner) begin s1.bvalid = m.bvalid; s1.bresp = m.bresp; end
        else          begin s0.bvalid = m.bvalid; s0.bresp = m.bresp; end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_axi_master_arbiter_2x1.sv
// Directed bench for axi_master_arbiter_2x1: bench plays both requesters and
// the downstream crossbar; expected values are hand-computed constants.
module tb_axi_master_arbiter_2x1;
  import axi_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  axi_master_arbiter_2x1_if s0_if ();
  axi_master_arbiter_2x1_if s1_if ();
  axi_master_arbiter_2x1_if m_if ();

  axi_master_arbiter_2x1 dut (
    .clk(clk), .rst(rst), .s0(s0_if), .s1(s1_if), .m(m_if)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
    end
  endtask

  task automatic clr_all();
    s0_if.arvalid = 0; s0_if.araddr = 0; s0_if.arlen = 0; s0_if.rready = 0;
    s0_if.awvalid = 0; s0_if.awaddr = 0; s0_if.awlen = 0; s0_if.wvalid = 0;
    s0_if.wdata = 0; s0_if.wstrb = 0; s0_if.wlast = 0; s0_if.bready = 0;
    s1_if.arvalid = 0; s1_if.araddr = 0; s1_if.arlen = 0; s1_if.rready = 0;
    s1_if.awvalid = 0; s1_if.awaddr = 0; s1_if.awlen = 0; s1_if.wvalid = 0;
    s1_if.wdata = 0; s1_if.wstrb = 0; s1_if.wlast = 0; s1_if.bready = 0;
    m_if.arready = 0; m_if.rvalid = 0; m_if.rdata = 0; m_if.rresp = 0; m_if.rlast = 0;
    m_if.awready = 0; m_if.wready = 0; m_if.bvalid = 0; m_if.bresp = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    clr_all();
    rst = 1;
    step();
    rst = 0;
  endtask

  // Cycle with no AR expected on the master port.
  task automatic idle_gap(input string tag);
    @(negedge clk);
    chk(tag, m_if.arvalid, 1'b0);
    step();
  endtask

  // Entered in the RD_ADDR cycle; completes AR and len+1 beats to port p.
  task automatic serve_read(input int p, input logic [31:0] addr, input logic [7:0] len,
                            input logic [31:0] dbase);
    m_if.arready = 1;
    @(negedge clk);
    chk("ar_valid", m_if.arvalid, 1'b1);
    chk("ar_addr", m_if.araddr, addr);
    chk("ar_len", m_if.arlen, len);
    chk("ar_rdy_own", (p != 0) ? s1_if.arready : s0_if.arready, 1'b1);
    chk("ar_rdy_oth", (p != 0) ? s0_if.arready : s1_if.arready, 1'b0);
    step();
    m_if.arready = 0;
    if (p != 0) s1_if.arvalid = 0; else s0_if.arvalid = 0;
    s0_if.rready = 1; s1_if.rready = 1;
    for (int i = 0; i <= int'(len); i++) begin
      m_if.rvalid = 1; m_if.rdata = dbase + i; m_if.rresp = RESP_OKAY;
      m_if.rlast = (i == int'(len));
      @(negedge clk);
      chk("r_vld_own", (p != 0) ? s1_if.rvalid : s0_if.rvalid, 1'b1);
      chk("r_data", (p != 0) ? s1_if.rdata : s0_if.rdata, dbase + i);
      chk("r_last", (p != 0) ? s1_if.rlast : s0_if.rlast, (i == int'(len)));
      chk("r_vld_oth", (p != 0) ? s0_if.rvalid : s1_if.rvalid, 1'b0);
      chk("m_rready", m_if.rready, 1'b1);
      step();
    end
    m_if.rvalid = 0; m_if.rlast = 0; m_if.rdata = 0;
    s0_if.rready = 0; s1_if.rready = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clr_all();
    rst = 1;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    // Reset state
    @(negedge clk);
    chk("rst_m_arvalid", m_if.arvalid, 1'b0);
    chk("rst_m_awvalid", m_if.awvalid, 1'b0);
    chk("rst_m_wvalid", m_if.wvalid, 1'b0);
    chk("rst_m_rready", m_if.rready, 1'b0);
    chk("rst_m_bready", m_if.bready, 1'b0);
    chk("rst_m_araddr", m_if.araddr, 32'h0);
    chk("rst_s0_arready", s0_if.arready, 1'b0);
    chk("rst_s1_rvalid", s1_if.rvalid, 1'b0);
    chk("rst_s0_bvalid", s0_if.bvalid, 1'b0);
    step();

    // Single read, port 0, 4 beats
    s0_if.arvalid = 1; s0_if.araddr = 32'h8000_0000; s0_if.arlen = 8'd3;
    idle_gap("t1_req_cycle");
    serve_read(0, 32'h8000_0000, 8'd3, 32'hA000_0000);

    // Simultaneous pairs
    do_reset();
    s0_if.arvalid = 1; s0_if.araddr = 32'h1000; s0_if.arlen = 0;
    s1_if.arvalid = 1; s1_if.araddr = 32'h2000; s1_if.arlen = 0;
    idle_gap("pair_req");
    serve_read(0, 32'h1000, 8'd0, 32'h1111_0000);
    s0_if.arvalid = 1; s0_if.araddr = 32'h1100;
    idle_gap("pair_turn1");
`ifdef AXI_ARB_FIXED_PRIO_EN
    serve_read(0, 32'h1100, 8'd0, 32'h1111_1000);
    idle_gap("pair_turn2");
    serve_read(1, 32'h2000, 8'd0, 32'h2222_0000);
`else
    serve_read(1, 32'h2000, 8'd0, 32'h2222_0000);
    idle_gap("pair_turn2");
    serve_read(0, 32'h1100, 8'd0, 32'h1111_1000);
`endif

    // Write: W handshakes before AW, SLVERR passed back
    s0_if.awvalid = 1; s0_if.awaddr = 32'h3000; s0_if.awlen = 0;
    s0_if.wvalid = 1; s0_if.wdata = 32'hDEAD_BEEF; s0_if.wstrb = 4'hF; s0_if.wlast = 1;
    s0_if.bready = 1;
    @(negedge clk);
    chk("w_idle_awvalid", m_if.awvalid, 1'b0);
    chk("w_idle_wready", s0_if.wready, 1'b0);
    step();
    m_if.wready = 1;
    @(negedge clk);
    chk("w_awvalid", m_if.awvalid, 1'b1);
    chk("w_awaddr", m_if.awaddr, 32'h3000);
    chk("w_wvalid", m_if.wvalid, 1'b1);
    chk("w_wdata", m_if.wdata, 32'hDEAD_BEEF);
    chk("w_wstrb", m_if.wstrb, 4'hF);
    chk("w_s0_wready", s0_if.wready, 1'b1);
    chk("w_s0_awready", s0_if.awready, 1'b0);
    step();
    s0_if.wvalid = 0; s0_if.wlast = 0; m_if.wready = 0;
    @(negedge clk);
    chk("w_wait_aw", m_if.awvalid, 1'b1);
    chk("w_wait_bready", m_if.bready, 1'b0);
    step();
    m_if.awready = 1;
    @(negedge clk);
    chk("w_s0_awready2", s0_if.awready, 1'b1);
    step();
    s0_if.awvalid = 0; m_if.awready = 0;
    m_if.bvalid = 1; m_if.bresp = RESP_SLVERR;
    @(negedge clk);
    chk("b_s0_bvalid", s0_if.bvalid, 1'b1);
    chk("b_s0_bresp", s0_if.bresp, RESP_SLVERR);
    chk("b_s1_bvalid", s1_if.bvalid, 1'b0);
    chk("b_m_bready", m_if.bready, 1'b1);
    chk("b_m_awvalid", m_if.awvalid, 1'b0);
    step();
    m_if.bvalid = 0; m_if.bresp = 0; s0_if.bready = 0;

    // Back-to-back reads from port 1: second AR two cycles after rlast
    s1_if.arvalid = 1; s1_if.araddr = 32'h6000; s1_if.arlen = 0;
    idle_gap("b2b_req");
    serve_read(1, 32'h6000, 8'd0, 32'h6666_0000);
    s1_if.arvalid = 1; s1_if.araddr = 32'h6100;
    idle_gap("b2b_k1");
    serve_read(1, 32'h6100, 8'd0, 32'h6666_1000);

    // Port 0 read concurrent with port 1 write
    s0_if.arvalid = 1; s0_if.araddr = 32'h4000; s0_if.arlen = 8'd1;
    s1_if.awvalid = 1; s1_if.awaddr = 32'h5000; s1_if.awlen = 0;
    s1_if.wvalid = 1; s1_if.wdata = 32'h1234_5678; s1_if.wstrb = 4'h3; s1_if.wlast = 1;
    s1_if.bready = 1; s0_if.rready = 1;
    step();
    m_if.arready = 1; m_if.awready = 1; m_if.wready = 1;
    @(negedge clk);
    chk("cc_araddr", m_if.araddr, 32'h4000);
    chk("cc_awaddr", m_if.awaddr, 32'h5000);
    chk("cc_wdata", m_if.wdata, 32'h1234_5678);
    chk("cc_s0_arready", s0_if.arready, 1'b1);
    chk("cc_s1_awready", s1_if.awready, 1'b1);
    chk("cc_s1_wready", s1_if.wready, 1'b1);
    chk("cc_s0_awready", s0_if.awready, 1'b0);
    chk("cc_s1_arready", s1_if.arready, 1'b0);
    step();
    s0_if.arvalid = 0; s1_if.awvalid = 0; s1_if.wvalid = 0; s1_if.wlast = 0;
    m_if.arready = 0; m_if.awready = 0; m_if.wready = 0;
    m_if.rvalid = 1; m_if.rdata = 32'hAAAA_0001; m_if.rlast = 0;
    m_if.bvalid = 1; m_if.bresp = RESP_OKAY;
    @(negedge clk);
    chk("cc_s0_rvalid", s0_if.rvalid, 1'b1);
    chk("cc_s0_rdata", s0_if.rdata, 32'hAAAA_0001);
    chk("cc_s1_rvalid", s1_if.rvalid, 1'b0);
    chk("cc_s1_bvalid", s1_if.bvalid, 1'b1);
    chk("cc_s0_bvalid", s0_if.bvalid, 1'b0);
    step();
    m_if.bvalid = 0; s1_if.bready = 0;
    m_if.rdata = 32'hAAAA_0002; m_if.rlast = 1;
    @(negedge clk);
    chk("cc_s0_rdata2", s0_if.rdata, 32'hAAAA_0002);
    chk("cc_s0_rlast", s0_if.rlast, 1'b1);
    chk("cc_wr_idle", m_if.bready, 1'b0);
    step();
    m_if.rvalid = 0; m_if.rlast = 0; m_if.rdata = 0; s0_if.rready = 0;

    // Reset during beat 2 of 4 (read pointer currently favours port 1)
    s0_if.arvalid = 1; s0_if.araddr = 32'h7000; s0_if.arlen = 8'd3;
    step();
    m_if.arready = 1;
    step();
    s0_if.arvalid = 0; m_if.arready = 0;
    s0_if.rready = 1; m_if.rvalid = 1; m_if.rdata = 32'h7777_0000;
    step();
    m_if.rdata = 32'h7777_0001;
    rst = 1;
    step();
    rst = 0;
    s0_if.arvalid = 1; s0_if.araddr = 32'h7100; s0_if.arlen = 0;
    s1_if.arvalid = 1; s1_if.araddr = 32'h7200; s1_if.arlen = 0;
    @(negedge clk);
    chk("mr_s0_rvalid", s0_if.rvalid, 1'b0);
    chk("mr_m_rready", m_if.rready, 1'b0);
    chk("mr_m_arvalid", m_if.arvalid, 1'b0);
    chk("mr_s0_arready", s0_if.arready, 1'b0);
    chk("mr_m_awvalid", m_if.awvalid, 1'b0);
    step();
    m_if.rvalid = 0; m_if.rdata = 0; s0_if.rready = 0;
    serve_read(0, 32'h7100, 8'd0, 32'h7777_1000);
    idle_gap("mr_turn");
    serve_read(1, 32'h7200, 8'd0, 32'h7777_2000);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
